// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word requests to instruction memory and
// buffers in-order responses for decode; redirects flush and drop wrong-path data.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [24:0] id_imm_field
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [31:0]   addr_q    [FIFO_DEPTH];
    logic [PW-1:0] buf_rd, buf_wr, aq_rd, aq_wr;
    logic [CW-1:0] fifo_count, outstanding, drop_cnt;
    logic [CW:0]   in_use, drop_next;
    logic          accept, enq, deq;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit rule: a request is only issued when its response is guaranteed a slot.
    assign in_use         = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    assign imem_req_valid = !rst && (state == FETCH) && (in_use < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign enq            = (state == FETCH) && imem_rsp_valid && !redirect_valid;
    assign deq            = id_valid && id_ready && !redirect_valid;

    // In DRAIN outstanding is zero and in FETCH drop_cnt is zero, so one sum serves both.
    assign drop_next = (CW+1)'(drop_cnt) + (CW+1)'(outstanding) + (CW+1)'(accept)
                     - (CW+1)'(imem_rsp_valid);

    assign id_valid     = (fifo_count != '0);
    assign id_instr     = id_valid ? buf_instr[buf_rd] : '0;
    assign id_pc        = id_valid ? buf_pc[buf_rd] : '0;
    assign id_pc_plus4  = id_valid ? (buf_pc[buf_rd] + 32'd4) : '0;
    assign id_imm_field = id_instr[31:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            buf_rd      <= '0;
            buf_wr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            buf_rd      <= '0;
            buf_wr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_next[CW-1:0];
            state       <= (drop_next[CW-1:0] != '0) ? DRAIN : FETCH;
        end else begin
            if (accept) begin
                pc    <= pc + 32'd4;
                aq_wr <= aq_wr + PW'(1);
            end
            if (enq) begin
                buf_wr <= buf_wr + PW'(1);
                aq_rd  <= aq_rd + PW'(1);
            end
            if (deq) begin
                buf_rd <= buf_rd + PW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(enq);
            fifo_count  <= fifo_count + CW'(enq) - CW'(deq);
            if (state == DRAIN && imem_rsp_valid) begin
                drop_cnt <= drop_cnt - CW'(1);
                if (drop_cnt == CW'(1)) begin
                    state <= FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !redirect_valid) begin
            addr_q[aq_wr] <= pc;
        end
        if (enq) begin
            buf_instr[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]    <= addr_q[aq_rd];
        end
    end

    rsp_without_request : assert property (@(posedge clk) disable iff (rst)
        !((state == FETCH) && imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus an
// in-order variable-latency memory, directed scenarios then randomized traffic.
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic [24:0] id_imm_field;

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_imm_field(id_imm_field)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
    typedef struct {logic [31:0] pc; logic [24:0] imm; logic [31:0] p4;} dq_t;

    mreq_t       mq[$];
    int          last_due = 0;
    int          cyc = 0;
    ent_t        m_fifo[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_pc;
    int          m_drop;

    int          rr_mode, ir_mode, lat_lo, lat_hi, redir_pct;
    bit          fr_en, redir_busy, redir_taken;
    logic [31:0] fr_pc;
    logic [31:0] acc_log[$];
    dq_t         deq_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hFFF0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit pick(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(3) != 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit rr, ir, rv, rd, acc, dq, mvalid;
        logic [31:0] rdata, rpc, a;
        int lat, due;
        @(negedge clk);
        rr    = pick(rr_mode);
        ir    = pick(ir_mode);
        rv    = (mq.size() != 0) && (mq[0].due <= cyc);
        rdata = rv ? mem_word(mq[0].addr) : $urandom;
        rpc   = $urandom;
        rd    = ($urandom_range(99) < redir_pct);
        if (fr_en) begin
            rd = 1'b1; rpc = fr_pc; fr_en = 1'b0;
        end
        if (redir_busy && rv && ir && m_fifo.size() != 0) begin
            rd = 1'b1; rpc = 32'h0000_0040; redir_busy = 1'b0; redir_taken = 1'b1;
        end
        imem_req_ready = rr;
        id_ready       = ir;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdata;
        redirect_valid = rd;
        redirect_pc    = rpc;
        #1;
        mvalid = (m_drop == 0) && (m_infl.size() + m_fifo.size() < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(mvalid));
        if (mvalid) chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("id_instr", id_instr, m_fifo[0].instr);
            chk("id_pc", id_pc, m_fifo[0].pc);
            chk("id_pc_plus4", id_pc_plus4, m_fifo[0].pc + 32'd4);
            chk("id_imm_field", 32'(id_imm_field), 32'(m_fifo[0].instr >> 7));
            chk("instr_matches_mem", id_instr, mem_word(id_pc));
        end
        acc = mvalid && rr;
        dq  = (m_fifo.size() != 0) && ir;
        if (imem_req_valid && rr) acc_log.push_back(imem_req_addr);
        if (id_valid && ir && !rd) deq_log.push_back('{pc: id_pc, imm: id_imm_field, p4: id_pc_plus4});
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (acc) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: m_pc, due: due});
            last_due = due;
        end
        cyc++;
        if (rd) begin
            m_drop = m_drop + m_infl.size() + int'(acc) - int'(rv);
            m_infl.delete();
            m_fifo.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (m_drop > 0) begin
            if (rv) m_drop--;
        end else begin
            if (dq) void'(m_fifo.pop_front());
            if (rv) begin
                a = m_infl.pop_front();
                m_fifo.push_back('{instr: rdata, pc: a});
            end
            if (acc) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("rst_id_imm", 32'(id_imm_field), 32'h0);
        imem_req_ready = 1'b0; id_ready = 1'b0; imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        mq.delete(); last_due = 0;
        m_fifo.delete(); m_infl.delete(); m_drop = 0; m_pc = RPC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_acc(input int n, input int lim);
        int k = 0;
        while (acc_log.size() < n && k < lim) begin step(); k++; end
        chk("acc_wait", 32'(acc_log.size() >= n), 32'h1);
    endtask

    task automatic run_until_deq(input int n, input int lim);
        int k = 0;
        while (deq_log.size() < n && k < lim) begin step(); k++; end
        chk("deq_wait", 32'(deq_log.size() >= n), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0; id_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
        fr_en = 1'b0; fr_pc = '0; redir_busy = 1'b0; redir_taken = 1'b0;
        redir_pct = 0; lat_lo = 1; lat_hi = 1; rr_mode = 1; ir_mode = 1;
        do_reset();

        // Sequential fetch with a 3-cycle memory stall at pc 0x8.
        acc_log.delete(); deq_log.delete();
        run_until_acc(2, 20);
        rr_mode = 0;
        repeat (3) begin
            step();
            #1 chk("stall_addr", imem_req_addr, 32'h0000_0008);
        end
        rr_mode = 1;
        run_until_acc(3, 20);
        run_until_deq(3, 20);
        chk("t1_acc0", acc_log[0], 32'h0);
        chk("t1_acc1", acc_log[1], 32'h4);
        chk("t1_acc2", acc_log[2], 32'h8);
        chk("t1_pc0", deq_log[0].pc, 32'h0);
        chk("t1_pc1", deq_log[1].pc, 32'h4);
        chk("t1_pc2", deq_log[2].pc, 32'h8);
        chk("t1_imm0", 32'(deq_log[0].imm), 32'h01FF_E001);
        chk("t1_plus4_0", deq_log[0].p4, 32'h4);

        // Decode back-pressure.
        rr_mode = 0; ir_mode = 1;
        repeat (6) step();
        acc_log.delete(); deq_log.delete();
        rr_mode = 1; ir_mode = 0;
        repeat (10) step();
        chk("bp_req_count", 32'(acc_log.size()), 32'(DEPTH));
        #1 chk("bp_req_valid_low", 32'(imem_req_valid), 32'h0);
        rr_mode = 0; ir_mode = 1;
        repeat (6) step();
        chk("bp_deq_count", 32'(deq_log.size()), 32'(DEPTH));
        chk("bp_deq_first", deq_log[0].pc, acc_log[0]);
        chk("bp_deq_second", deq_log[1].pc, acc_log[0] + 32'd4);

        // Redirect with two responses in flight, 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        repeat (6) step();
        acc_log.delete(); deq_log.delete();
        rr_mode = 1;
        run_until_acc(2, 20);
        rr_mode = 0; fr_en = 1'b1; fr_pc = 32'h0000_0103;
        step();
        rr_mode = 1;
        run_until_deq(1, 40);
        chk("t4_first_req", acc_log[2], 32'h0000_0100);
        chk("t4_first_pc", deq_log[0].pc, 32'h0000_0100);

        // Redirect coinciding with a response and a dequeue.
        lat_lo = 1; lat_hi = 1; rr_mode = 1; ir_mode = 1;
        redir_taken = 1'b0; redir_busy = 1'b1;
        begin
            int k = 0;
            while (!redir_taken && k < 40) begin step(); k++; end
        end
        redir_busy = 1'b0;
        chk("t5_redirect_hit", 32'(redir_taken), 32'h1);
        #1 chk("t5_fifo_flushed", 32'(id_valid), 32'h0);
        deq_log.delete();
        run_until_deq(1, 40);
        chk("t5_first_pc", deq_log[0].pc, 32'h0000_0040);

        // Address wrap, then asynchronous reset mid-fetch.
        rr_mode = 0; fr_en = 1'b1; fr_pc = 32'hFFFF_FFFF;
        step();
        acc_log.delete();
        rr_mode = 1;
        run_until_acc(2, 30);
        chk("t6_wrap0", acc_log[0], 32'hFFFF_FFFC);
        chk("t6_wrap1", acc_log[1], 32'h0);
        step();
        do_reset();
        acc_log.delete();
        run_until_acc(1, 10);
        chk("t6_after_reset", acc_log[0], RPC);

        // Randomized traffic with redirects and occasional resets.
        rr_mode = 2; ir_mode = 2; lat_lo = 1; lat_hi = 4; redir_pct = 4;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i % 800 == 799) do_reset();
            if (acc_log.size() > 64) acc_log.delete();
            if (deq_log.size() > 64) deq_log.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the RISC-V core. Holds the PC and issues word requests to instruction memory. Buffers returned instructions in a small in-order FIFO and presents them to decode with their PC. Decode feeds id_imm_field straight into the sign extender's in[24:0] input. Handles decode back-pressure and branch/jump redirects, dropping wrong-path responses that are still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address (= pc)
imem_rsp_valid  in  1  response valid; in order, one per accepted request, latency >=1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken, flush and refetch
redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
id_valid  out  1  FIFO head valid to decode
id_ready  in  1  decode consumes head
id_instr  out  32  head instruction
id_pc  out  32  PC of head instruction
id_pc_plus4  out  32  id_pc + 4, mod 2^32
id_imm_field  out  25  id_instr[31:7]; feeds sign extender

Behaviour:
- Reset (async assert): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=FETCH. During reset: imem_req_valid=0, id_valid=0; id_instr, id_pc, id_pc_plus4 and id_imm_field all 0.
- FSM states FETCH and DRAIN.
- FETCH: imem_req_valid=1 iff (outstanding + fifo_count) < FIFO_DEPTH. This credit rule guarantees every response has a free slot, so no response is ever refused.
- Request accept: imem_req_valid && imem_req_ready. On accept, pc <= pc+4 (wraps 0xFFFF_FFFC -> 0) and outstanding += 1.
- FIFO entry is {instr, pc}. The pc is captured at request accept into a parallel in-flight address queue of FIFO_DEPTH entries.
- Response in FETCH: enqueue and outstanding -= 1. If enqueue and dequeue happen in the same cycle, count is unchanged.
- id_valid = (fifo_count != 0), driven from registered storage. Head is dequeued when id_valid && id_ready.
- Latency: request accepted in cycle N, response in cycle N+k gives id_valid at N+k+1.
- Redirect (highest priority over every other event in that cycle):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO and address queue flushed; id_valid=0 next cycle. A dequeue in the same cycle is ignored.
  - drop_cnt <= outstanding + (req accepted this cycle) - (rsp_valid this cycle). A response arriving in the redirect cycle is discarded.
  - outstanding <= 0.
  - If the new drop_cnt is nonzero, state <= DRAIN; otherwise state stays FETCH.
- DRAIN: imem_req_valid=0. Each imem_rsp_valid is discarded and drop_cnt -= 1. When drop_cnt reaches 0 (including on the last discarded response), state <= FETCH, and requests resume the next cycle.
- Redirect in DRAIN: pc reloaded, drop_cnt <= drop_cnt - rsp_valid, and stay in DRAIN unless drop_cnt becomes 0.
- imem_req_addr is stable while imem_req_valid && !imem_req_ready, except across a redirect.
- Reset asserted mid-operation: all state cleared immediately. In-flight memory responses after reset are the memory's responsibility (memory is reset together with this block).
- Counters are sized for 0..FIFO_DEPTH and never over- or underflow. A response with outstanding=0 in FETCH is illegal; flag it with an assertion.

Test Plan:
1. Reset then sequential fetch, 1-cycle memory, id_ready=1. Requests go to 0x0, 0x4, 0x8. id_pc follows 0x0, 0x4, 0x8. Feeding 0xFFF00093 at pc 0 gives id_imm_field=0x1FFE001 and id_pc_plus4=0x4.
2. Back-pressure: id_ready=0 for 10 cycles. Exactly FIFO_DEPTH requests are issued, then imem_req_valid=0. Raise id_ready and instructions drain in order with no loss or duplication.
3. Memory stall: imem_req_ready=0 for 3 cycles at pc 0x8. imem_req_addr holds 0x8 and pc does not advance.
4. Redirect with 2 responses in flight (3-cycle memory latency), redirect_pc=0x0000_0103. Both old responses are dropped. The next request is to 0x100, the first id_pc is 0x100, and no stale instruction reaches decode.
5. Redirect in the same cycle as a response and as a decode dequeue. Response and dequeue are ignored, the FIFO is empty next cycle, and drop_cnt is correct (no hang in DRAIN).
6. Wrap-around and async reset: redirect to 0xFFFF_FFFC, then fetch addresses 0xFFFF_FFFC, 0x0. Assert rst mid-fetch with no clock edge: outputs clear immediately, and the first request after release is to RESET_PC.
